// File: rtl/audio_memory_sequencer.sv
// Record/playback sequencer between an audio controller, a sample RAM and the ADC/DAC.
// Samples are paced by a divider; reads return through a two-stage pipeline to the DAC.
module audio_memory_sequencer #(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 8,
  parameter int SAMPLE_DIV = 2500
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              StartRecord,
  input  logic              StartPlay,
  input  logic              StopPlaying,
  input  logic [DATA_W-1:0] SampleIn,
  input  logic [DATA_W-1:0] MemRdData,
  output logic [ADDR_W-1:0] MemAddr,
  output logic [DATA_W-1:0] MemWrData,
  output logic              MemWe,
  output logic              MemRe,
  output logic [DATA_W-1:0] SampleOut,
  output logic              SampleOutValid,
  output logic              MemoryFull,
  output logic              StopReading
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int DIV_W = $clog2(SAMPLE_DIV);

  typedef enum logic [2:0] {IDLE, REC, FULL, PLAY, END} state_t;

  state_t            state;
  logic [DIV_W-1:0]  div_cnt;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   rec_len;
  logic              rd_vld_p1;

  logic              tick;
  logic [DIV_W-1:0]  div_nxt;
  logic              rec_abort;
  logic              play_abort;
  logic              last_wr;
  logic              last_rd;

  assign tick       = (div_cnt == DIV_W'(SAMPLE_DIV - 1));
  assign div_nxt    = tick ? '0 : div_cnt + DIV_W'(1);
  assign rec_abort  = !StartRecord || StopPlaying;
  assign play_abort = !StartPlay || StopPlaying;
  assign last_wr    = &wr_ptr;
  assign last_rd    = ({1'b0, rd_ptr} == rec_len - (ADDR_W+1)'(1));

  // Status flags decode straight from the registered state so they hold until the controller reacts
  assign MemoryFull  = (state == FULL);
  assign StopReading = (state == END);

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state          <= IDLE;
      div_cnt        <= '0;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      rec_len        <= '0;
      MemAddr        <= '0;
      MemWrData      <= '0;
      MemWe          <= 1'b0;
      MemRe          <= 1'b0;
      rd_vld_p1      <= 1'b0;
      SampleOut      <= '0;
      SampleOutValid <= 1'b0;
    end else begin
      MemWe     <= 1'b0;
      MemRe     <= 1'b0;
      MemAddr   <= '0;
      MemWrData <= '0;
      div_cnt   <= '0;

      // p1: RAM data valid; p2: sample presented to the DAC, independent of the FSM
      rd_vld_p1      <= MemRe;
      SampleOutValid <= rd_vld_p1;
      if (rd_vld_p1) SampleOut <= MemRdData;

      case (state)
        IDLE: begin
          if (StartRecord) begin
            state  <= REC;
            wr_ptr <= '0;
          end else if (StartPlay) begin
            rd_ptr <= '0;
            state  <= (rec_len == '0) ? END : PLAY;
          end
        end
        REC: begin
          if (rec_abort) begin
            state   <= IDLE;
            rec_len <= {1'b0, wr_ptr};
          end else begin
            div_cnt <= div_nxt;
            if (tick) begin
              MemWe     <= 1'b1;
              MemAddr   <= wr_ptr;
              MemWrData <= SampleIn;
              if (last_wr) begin
                state   <= FULL;
                rec_len <= (ADDR_W+1)'(DEPTH);
              end else begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
              end
            end
          end
        end
        FULL: if (rec_abort) state <= IDLE;
        PLAY: begin
          if (play_abort) begin
            state <= IDLE;
          end else begin
            div_cnt <= div_nxt;
            if (tick) begin
              MemRe   <= 1'b1;
              MemAddr <= rd_ptr;
              rd_ptr  <= rd_ptr + ADDR_W'(1);
              if (last_rd) state <= END;
            end
          end
        end
        END: if (play_abort) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_audio_memory_sequencer.sv
// Directed bench for audio_memory_sequencer with a small synchronous RAM model.
module tb_audio_memory_sequencer;

  localparam int AW = 3;
  localparam int DW = 8;
  localparam int SD = 4;

  logic          Clock;
  logic          Reset;
  logic          StartRecord;
  logic          StartPlay;
  logic          StopPlaying;
  logic [DW-1:0] SampleIn;
  logic [DW-1:0] MemRdData;
  logic [AW-1:0] MemAddr;
  logic [DW-1:0] MemWrData;
  logic          MemWe;
  logic          MemRe;
  logic [DW-1:0] SampleOut;
  logic          SampleOutValid;
  logic          MemoryFull;
  logic          StopReading;

  audio_memory_sequencer #(.ADDR_W(AW), .DATA_W(DW), .SAMPLE_DIV(SD)) dut (
    .Clock(Clock), .Reset(Reset), .StartRecord(StartRecord), .StartPlay(StartPlay),
    .StopPlaying(StopPlaying), .SampleIn(SampleIn), .MemRdData(MemRdData),
    .MemAddr(MemAddr), .MemWrData(MemWrData), .MemWe(MemWe), .MemRe(MemRe),
    .SampleOut(SampleOut), .SampleOutValid(SampleOutValid),
    .MemoryFull(MemoryFull), .StopReading(StopReading)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  logic [DW-1:0] ram [0:(1<<AW)-1];
  always @(posedge Clock) begin
    if (MemWe) ram[MemAddr] <= MemWrData;
    if (MemRe) MemRdData <= ram[MemAddr];
  end

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int tot_wr = 0;
  int wr_base = 0;
  int idle_bad = 0;
  int full_first = -1;
  int sr_first = -1;
  logic [DW-1:0] sin_base = 8'h10;
  logic [AW-1:0] wa [$];
  logic [DW-1:0] wd [$];
  int            wc [$];
  logic [AW-1:0] ra [$];
  int            rc [$];
  logic [DW-1:0] so [$];
  int            sc [$];

  // Each captured sample is base + index of the write within the current session
  assign SampleIn = sin_base + 8'(tot_wr - wr_base);

  always @(posedge Clock) cyc++;

  always @(negedge Clock) begin
    if (MemWe) begin
      wa.push_back(MemAddr); wd.push_back(MemWrData); wc.push_back(cyc); tot_wr++;
    end
    if (MemRe) begin
      ra.push_back(MemAddr); rc.push_back(cyc);
    end
    if (SampleOutValid) begin
      so.push_back(SampleOut); sc.push_back(cyc);
    end
    if (MemoryFull && full_first < 0) full_first = cyc;
    if (StopReading && sr_first < 0) sr_first = cyc;
    if (!MemWe && !MemRe && (MemAddr != '0 || MemWrData != '0)) idle_bad++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge Clock);
    #1;
  endtask

  task automatic clr();
    wa.delete(); wd.delete(); wc.delete();
    ra.delete(); rc.delete(); so.delete(); sc.delete();
    full_first = -1;
    sr_first = -1;
    wr_base = tot_wr;
  endtask

  task automatic wait_wr(input int n, input string tag);
    int k = 0;
    while (wa.size() < n && k < 100) begin step(1); k++; end
    check(tag, 32'(wa.size() >= n), 1);
  endtask

  task automatic wait_rd(input int n, input string tag);
    int k = 0;
    while (ra.size() < n && k < 100) begin step(1); k++; end
    check(tag, 32'(ra.size() >= n), 1);
  endtask

  task automatic wait_sig(input int which, input string tag);
    int k = 0;
    while (((which == 0) ? MemoryFull : StopReading) !== 1'b1 && k < 100) begin step(1); k++; end
    check(tag, 32'(k < 100), 1);
  endtask

  task automatic check_outs_zero(input string tag);
    check(tag, 32'({MemAddr, MemWrData, MemWe, MemRe, SampleOut, SampleOutValid,
                    MemoryFull, StopReading}), 0);
  endtask

  initial begin
    Reset = 1'b0; StartRecord = 1'b0; StartPlay = 1'b0; StopPlaying = 1'b0;
    step(3);
    check_outs_zero("reset_outs");
    Reset = 1'b1;

    // Empty play right after reset: nothing recorded yet
    clr();
    StartPlay = 1'b1;
    check("empty_sr_pre", 32'(StopReading), 0);
    step(1);
    check("empty_sr", 32'(StopReading), 1);
    step(15);
    check("empty_rd_cnt", ra.size(), 0);
    check("empty_so_cnt", so.size(), 0);
    StartPlay = 1'b0;
    step(1);
    check("empty_sr_clr", 32'(StopReading), 0);

    // Full record of 8 samples
    clr();
    sin_base = 8'h10;
    StartRecord = 1'b1;
    wait_sig(0, "full_wait");
    step(5);
    check("full_wr_cnt", wa.size(), 8);
    for (int i = 0; i < wa.size() && i < 8; i++) begin
      check($sformatf("full_addr%0d", i), 32'(wa[i]), i);
      check($sformatf("full_data%0d", i), 32'(wd[i]), 32'h10 + i);
      if (i > 0) check($sformatf("full_gap%0d", i), wc[i] - wc[i-1], 4);
    end
    if (wa.size() == 8) check("full_at_wr8", full_first, wc[7]);
    check("full_hold", 32'(MemoryFull), 1);
    StartRecord = 1'b0;
    step(1);
    check("full_clr", 32'(MemoryFull), 0);

    // Play back all 8
    clr();
    StartPlay = 1'b1;
    wait_sig(1, "play8_wait");
    step(4);
    check("play8_rd_cnt", ra.size(), 8);
    check("play8_so_cnt", so.size(), 8);
    for (int i = 0; i < ra.size() && i < 8; i++)
      check($sformatf("play8_addr%0d", i), 32'(ra[i]), i);
    for (int i = 0; i < so.size() && i < 8; i++)
      check($sformatf("play8_so%0d", i), 32'(so[i]), 32'h10 + i);
    StartPlay = 1'b0;
    step(2);

    // Stop mid-play after 2 reads, then restart
    clr();
    StartPlay = 1'b1;
    wait_rd(2, "stop_wait");
    StopPlaying = 1'b1;
    step(20);
    check("stop_rd_cnt", ra.size(), 2);
    check("stop_so_cnt", so.size(), 2);
    if (so.size() == 2) check("stop_so1", 32'(so[1]), 32'h11);
    check("stop_sr", 32'(StopReading), 0);
    clr();
    StopPlaying = 1'b0;
    wait_rd(1, "restart_wait");
    if (ra.size() > 0) check("restart_addr", 32'(ra[0]), 0);
    StartPlay = 1'b0;
    step(4);

    // Reset in the middle of a recording discards it
    clr();
    StartRecord = 1'b1;
    wait_wr(5, "rstrec_wait");
    Reset = 1'b0;
    StartRecord = 1'b0;
    step(1);
    Reset = 1'b1;
    check_outs_zero("rstrec_outs");
    step(20);
    check("rstrec_wr_cnt", wa.size(), 5);
    clr();
    StartPlay = 1'b1;
    step(1);
    check("rstrec_sr", 32'(StopReading), 1);
    step(10);
    check("rstrec_rd_cnt", ra.size(), 0);
    StartPlay = 1'b0;
    step(2);

    // Abort after 3 writes, then play the short recording
    clr();
    sin_base = 8'h40;
    StartRecord = 1'b1;
    wait_wr(3, "abort_wait");
    StartRecord = 1'b0;
    step(2);
    check("abort_wr_cnt", wa.size(), 3);
    StartPlay = 1'b1;
    wait_sig(1, "abort_play_wait");
    step(8);
    check("abort_rd_cnt", ra.size(), 3);
    check("abort_so_cnt", so.size(), 3);
    for (int i = 0; i < ra.size() && i < 3; i++)
      check($sformatf("abort_addr%0d", i), 32'(ra[i]), i);
    for (int i = 0; i < so.size() && i < 3; i++)
      check($sformatf("abort_so%0d", i), 32'(so[i]), 32'h40 + i);
    if (ra.size() == 3) check("abort_sr_at_rd3", sr_first, rc[2]);
    if (ra.size() == 3 && so.size() == 3) check("abort_last_lat", sc[2] - rc[2], 2);
    check("abort_sr_hold", 32'(StopReading), 1);
    StartPlay = 1'b0;
    step(1);
    check("abort_sr_clr", 32'(StopReading), 0);

    // Simultaneous start: record wins
    clr();
    StartRecord = 1'b1;
    StartPlay = 1'b1;
    step(18);
    StartRecord = 1'b0;
    StartPlay = 1'b0;
    step(3);
    check("simul_wr_cnt", wa.size(), 4);
    check("simul_rd_cnt", ra.size(), 0);

    check("idle_bus_zero", idle_bad, 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
